// File: rtl/dot_product_accumulator_pkg.sv
// Shared types and saturating arithmetic for the dot-product accumulator.
// Widths are carried in a fixed wide type so one helper serves any ACC_W.
package dot_acc_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ACCUM,
        DONE
    } state_t;

    localparam int N_DEF     = 5;
    localparam int LEN_DEF   = 4;
    localparam int ACC_W_DEF = 2 * N_DEF + $clog2(LEN_DEF);

    // Wide enough that acc + addend never wraps for any practical ACC_W.
    localparam int SAT_W = 64;
    typedef logic signed [SAT_W-1:0] wide_t;

    // Adds two sign-extended operands and clamps the sum to the signed range
    // of accW bits; ovf reports whether clamping happened.
    function automatic wide_t sat_add(input wide_t acc, input wide_t addend,
                                      input int accW, output logic ovf);
        wide_t sum;
        wide_t maxV;
        wide_t minV;
        sum  = acc + addend;
        maxV = (wide_t'(1) <<< (accW - 1)) - wide_t'(1);
        minV = -maxV - wide_t'(1);
        ovf  = 1'b0;
        if (sum > maxV) begin
            sum = maxV;
            ovf = 1'b1;
        end else if (sum < minV) begin
            sum = minV;
            ovf = 1'b1;
        end
        return sum;
    endfunction

endpackage

// File: rtl/dot_product_accumulator_if.sv
// Product input stream and result output stream of the dot-product accumulator.
// The slave modport is the accumulator; the master is whoever drives products.
interface dot_product_accumulator_if #(
    parameter int N     = 5,
    parameter int ACC_W = 12
);
    logic             in_valid;
    logic             in_ready;
    logic [2*N-1:0]   product;
    logic             out_valid;
    logic             out_ready;
    logic [ACC_W-1:0] result;
    logic             ovf;

    modport slave (
        input  in_valid, product, out_ready,
        output in_ready, out_valid, result, ovf
    );

    modport master (
        output in_valid, product, out_ready,
        input  in_ready, out_valid, result, ovf
    );
endinterface

// File: rtl/dot_product_accumulator.sv
// Sums groups of LEN signed products into a saturating accumulator and holds
// each finished dot-product on a registered valid/ready output.
module dot_product_accumulator
    import dot_acc_pkg::*;
#(
    parameter int N     = N_DEF,
    parameter int LEN   = LEN_DEF,
    parameter int ACC_W = 2 * N + $clog2(LEN)
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    dot_product_accumulator_if.slave bus
);

    localparam int CNT_W = $clog2(LEN);

    state_t                  state_q;
    logic signed [ACC_W-1:0] acc_q;
    logic signed [ACC_W-1:0] result_q;
    logic [CNT_W-1:0]        count_q;
    logic                    ovfInt_q;
    logic                    ovf_q;
    logic                    outValid_q;

    logic signed [ACC_W-1:0] acc_d;
    logic                    satOvf_d;
    logic                    lastBeat;
    wide_t                   accWide;
    wide_t                   prodWide;

    always_comb begin
        accWide  = {{(SAT_W - ACC_W){acc_q[ACC_W-1]}}, acc_q};
        prodWide = {{(SAT_W - 2 * N){bus.product[2*N-1]}}, bus.product};
        satOvf_d = 1'b0;
        acc_d    = ACC_W'(sat_add(accWide, prodWide, ACC_W, satOvf_d));
    end

    assign lastBeat = (count_q == CNT_W'(LEN - 1));

    // Clear beats both a simultaneous accept and a simultaneous output handshake.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            acc_q      <= '0;
            count_q    <= '0;
            ovfInt_q   <= 1'b0;
            result_q   <= '0;
            ovf_q      <= 1'b0;
            outValid_q <= 1'b0;
        end else if (clear) begin
            state_q    <= IDLE;
            acc_q      <= '0;
            count_q    <= '0;
            ovfInt_q   <= 1'b0;
            ovf_q      <= 1'b0;
            outValid_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE, ACCUM: begin
                    if (bus.in_valid) begin
                        acc_q    <= acc_d;
                        ovfInt_q <= ovfInt_q | satOvf_d;
                        if (lastBeat) begin
                            result_q   <= acc_d;
                            ovf_q      <= ovfInt_q | satOvf_d;
                            outValid_q <= 1'b1;
                            state_q    <= DONE;
                        end else begin
                            count_q <= count_q + CNT_W'(1);
                            state_q <= ACCUM;
                        end
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        outValid_q <= 1'b0;
                        ovf_q      <= 1'b0;
                        acc_q      <= '0;
                        count_q    <= '0;
                        ovfInt_q   <= 1'b0;
                        state_q    <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign bus.in_ready  = (state_q != DONE);
    assign bus.out_valid = outValid_q;
    assign bus.result    = result_q;
    assign bus.ovf       = ovf_q;

endmodule

// File: tb/tb_dot_product_accumulator.sv
// Directed bench: a default-width and a narrow (ACC_W=10) accumulator side by
// side, driven from a vector table plus hand-written multi-cycle sequences.
module tb_dot_product_accumulator;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic clearA = 1'b0;
    logic clearB = 1'b0;

    int testsRun = 0;
    int testsFailed = 0;

    always #5 clk = ~clk;

    dot_product_accumulator_if #(.N(5), .ACC_W(12)) ifA ();
    dot_product_accumulator_if #(.N(5), .ACC_W(10)) ifB ();

    dot_product_accumulator #(.N(5), .LEN(4), .ACC_W(12)) dutA (
        .clk(clk), .rst(rst), .clear(clearA), .bus(ifA)
    );
    dot_product_accumulator #(.N(5), .LEN(4), .ACC_W(10)) dutB (
        .clk(clk), .rst(rst), .clear(clearB), .bus(ifB)
    );

    typedef struct {
        int    sel;
        int    p0, p1, p2, p3;
        int    gap;
        int    expRes;
        int    expOvf;
        string name;
    } vec_t;

    vec_t vecs[$];

    task automatic checkOutput(input string name, input int act, input int exp);
        testsRun++;
        if (act != exp) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic int resultOf(input int sel);
        if (sel == 0) return int'($signed(ifA.result));
        return int'($signed(ifB.result));
    endfunction

    function automatic int validOf(input int sel);
        return (sel == 0) ? int'(ifA.out_valid) : int'(ifB.out_valid);
    endfunction

    function automatic int readyOf(input int sel);
        return (sel == 0) ? int'(ifA.in_ready) : int'(ifB.in_ready);
    endfunction

    function automatic int ovfOf(input int sel);
        return (sel == 0) ? int'(ifA.ovf) : int'(ifB.ovf);
    endfunction

    task automatic driveIn(input int sel, input logic v, input int val);
        if (sel == 0) begin
            ifA.in_valid = v;
            ifA.product  = 10'(val);
        end else begin
            ifB.in_valid = v;
            ifB.product  = 10'(val);
        end
    endtask

    // Entered and left at a negedge; presents one beat until it is accepted.
    task automatic applyStimulus(input int sel, input int val);
        int waitCnt = 0;
        driveIn(sel, 1'b1, val);
        while (readyOf(sel) == 0 && waitCnt < 20) begin
            @(negedge clk);
            waitCnt++;
        end
        if (waitCnt >= 20) begin
            checkOutput("inReadyTimeout", 0, 1);
            driveIn(sel, 1'b0, 0);
        end else begin
            @(posedge clk);
            @(negedge clk);
            driveIn(sel, 1'b0, 0);
        end
    endtask

    task automatic runGroup(input int sel, input int p0, input int p1, input int p2,
                            input int p3, input int gap, input int expRes,
                            input int expOvf, input string name);
        int vals[4];
        logic outRdy;
        vals = '{p0, p1, p2, p3};
        outRdy = (sel == 0) ? ifA.out_ready : ifB.out_ready;
        for (int i = 0; i < 4; i++) begin
            applyStimulus(sel, vals[i]);
            if (i < 3) begin
                checkOutput({name, ".earlyValid"}, validOf(sel), 0);
                repeat (gap) @(negedge clk);
            end
        end
        checkOutput({name, ".outValid"}, validOf(sel), 1);
        checkOutput({name, ".result"}, resultOf(sel), expRes);
        checkOutput({name, ".ovf"}, ovfOf(sel), expOvf);
        checkOutput({name, ".inReadyDone"}, readyOf(sel), 0);
        if (outRdy) begin
            @(negedge clk);
            checkOutput({name, ".validDrop"}, validOf(sel), 0);
            checkOutput({name, ".inReadyBack"}, readyOf(sel), 1);
        end
    endtask

    task automatic addVec(input int sel, input int p0, input int p1, input int p2,
                          input int p3, input int gap, input int expRes,
                          input int expOvf, input string name);
        vec_t v;
        v.sel = sel; v.p0 = p0; v.p1 = p1; v.p2 = p2; v.p3 = p3;
        v.gap = gap; v.expRes = expRes; v.expOvf = expOvf; v.name = name;
        vecs.push_back(v);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        ifA.in_valid = 1'b0; ifA.product = '0; ifA.out_ready = 1'b1;
        ifB.in_valid = 1'b0; ifB.product = '0; ifB.out_ready = 1'b1;

        addVec(0, 15, -9, 6, -50, 0, -38, 0, "A.mixed");
        addVec(0, 5, -5, 20, -1, 2, 19, 0, "A.gaps");
        addVec(0, -512, -512, -512, -512, 0, -2048, 0, "A.exactMin");
        addVec(0, 511, 511, 511, 511, 0, 2044, 0, "A.nearMax");
        addVec(1, 256, 256, 256, 256, 0, 511, 1, "B.satPos");
        addVec(1, 1, 1, 1, 1, 0, 4, 0, "B.afterSat");
        addVec(1, -512, -512, 1, 1, 0, -510, 1, "B.satNeg");
        addVec(1, 256, 256, -1, 0, 0, 510, 1, "B.fromClamp");
        addVec(1, 511, 0, 0, 0, 1, 511, 0, "B.exactMax");
        addVec(1, -256, -256, 0, 0, 0, -512, 0, "B.exactMin");

        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1;
        checkOutput("reset.inReady", int'(ifA.in_ready), 1);
        checkOutput("reset.outValid", int'(ifA.out_valid), 0);
        checkOutput("reset.result", resultOf(0), 0);
        checkOutput("reset.ovf", int'(ifA.ovf), 0);
        @(negedge clk);

        foreach (vecs[i]) begin
            runGroup(vecs[i].sel, vecs[i].p0, vecs[i].p1, vecs[i].p2, vecs[i].p3,
                     vecs[i].gap, vecs[i].expRes, vecs[i].expOvf, vecs[i].name);
        end

        // Backpressure: result held while a pending product waits.
        ifA.out_ready = 1'b0;
        runGroup(0, 3, 3, 3, 3, 0, 12, 0, "bp");
        driveIn(0, 1'b1, 7);
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            checkOutput("bp.holdValid", int'(ifA.out_valid), 1);
            checkOutput("bp.holdResult", resultOf(0), 12);
            checkOutput("bp.holdInReady", int'(ifA.in_ready), 0);
        end
        ifA.out_ready = 1'b1;
        @(negedge clk);
        checkOutput("bp.released", int'(ifA.out_valid), 0);
        checkOutput("bp.inReady", int'(ifA.in_ready), 1);
        @(posedge clk);
        @(negedge clk);
        driveIn(0, 1'b0, 0);
        applyStimulus(0, 1);
        applyStimulus(0, 1);
        applyStimulus(0, 1);
        checkOutput("bp.nextValid", int'(ifA.out_valid), 1);
        checkOutput("bp.nextResult", resultOf(0), 10);
        @(negedge clk);

        // Clear mid-group, with a beat presented alongside it.
        applyStimulus(0, 100);
        applyStimulus(0, 100);
        driveIn(0, 1'b1, 100);
        clearA = 1'b1;
        @(posedge clk);
        @(negedge clk);
        clearA = 1'b0;
        driveIn(0, 1'b0, 0);
        checkOutput("clr.inReady", int'(ifA.in_ready), 1);
        checkOutput("clr.outValid", int'(ifA.out_valid), 0);
        runGroup(0, 1, 2, 3, 4, 0, 10, 0, "clr.after");

        // Clear while a result is waiting for the consumer.
        ifA.out_ready = 1'b0;
        runGroup(0, 1, 1, 1, 1, 0, 4, 0, "clrDone");
        clearA = 1'b1;
        @(negedge clk);
        clearA = 1'b0;
        checkOutput("clrDone.outValid", int'(ifA.out_valid), 0);
        checkOutput("clrDone.resultKept", resultOf(0), 4);
        checkOutput("clrDone.inReady", int'(ifA.in_ready), 1);
        ifA.out_ready = 1'b1;
        runGroup(0, 2, 2, 2, 2, 0, 8, 0, "clrDone.after");

        // Asynchronous reset between edges after two beats.
        applyStimulus(0, 50);
        applyStimulus(0, 50);
        #2 rst = 1'b1;
        #1;
        checkOutput("arst.result", resultOf(0), 0);
        checkOutput("arst.outValid", int'(ifA.out_valid), 0);
        checkOutput("arst.inReady", int'(ifA.in_ready), 1);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        runGroup(0, 1, 1, 1, 1, 0, 4, 0, "arst.after");

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule

// File: doc/dot_product_accumulator.md
Name: dot_product_accumulator

Overview:
- Downstream stage of the signed N-bit combinational multiplier.
- Consumes a stream of signed 2N-bit products over a valid/ready handshake.
- Sums each group of LEN consecutive products into a signed ACC_W-bit accumulator, saturating on overflow.
- Presents each finished dot-product on a registered valid/ready output port, with a sticky overflow flag.

Parameters:
- N, 5: multiplier operand width; input product is 2*N bits, signed two's complement.
- LEN, 4: products per dot-product, ≥2.
- ACC_W, 2*N+$clog2(LEN): accumulator/result width, ≥2*N; smaller than default makes saturation reachable.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- clear  input  1  synchronous abort of the current dot-product.
- in_valid  input  1  product is valid.
- in_ready  output  1  block accepts a product this cycle.
- product  input  2*N  signed product from the multiplier.
- out_valid  output  1  result and ovf are valid.
- out_ready  input  1  consumer takes the result.
- result  output  ACC_W  signed dot-product.
- ovf  output  1  saturation occurred during this dot-product.

Behaviour:
- Reset (async assert, sync use):
  - state=IDLE, acc=0, count=0.
  - result=0, ovf=0, out_valid=0.
  - in_ready=1 from the first cycle after rst deasserts.
- States:
  - IDLE: no beat yet in the group.
  - ACCUM: 1..LEN-1 beats accepted.
  - DONE: result held on output.
- in_ready is 1 in IDLE/ACCUM and 0 in DONE. It is a function of state only; no combinational path from in_valid or out_ready.
- Accept happens when in_valid&&in_ready at a clock edge. On accept:
  - next = acc + sign_extend(product) to ACC_W+1 bits.
  - If next > 2^(ACC_W-1)-1: acc = max positive, sticky ovf_int=1.
  - If next < -2^(ACC_W-1): acc = min negative, ovf_int=1.
  - Otherwise acc = next.
  - count++. IDLE→ACCUM on the first beat.
- On accepting beat number LEN (count==LEN-1):
  - result ← saturated sum, ovf ← ovf_int.
  - out_valid=1, state→DONE, in the same edge.
  - Latency: result visible the cycle after the last accepted beat.
- DONE: result, ovf and out_valid are held stable until out_valid&&out_ready. On that edge:
  - out_valid=0, acc=0, count=0, ovf_int=0, state→IDLE.
  - The next product can be accepted one cycle later; no bubble-free overlap is required.
- in_valid low in IDLE/ACCUM: hold all state, no timeout.
- clear=1 at an edge, in any state:
  - acc=0, count=0, ovf_int=0, out_valid=0, state→IDLE.
  - clear takes priority over a simultaneous accept and over a simultaneous output handshake.
  - A beat presented with clear is dropped.
  - result keeps its last value but is not valid.
- rst mid-operation: immediate return to the reset values; the partial sum is lost.
- Once saturated, the accumulator keeps adding from the clamped value. For example, max + (-1) gives max-1. ovf stays 1 for that group.
- ovf is reported only with out_valid and is 0 for a group that never saturated.
- All arithmetic is signed. Product sign is bit 2N-1.

Decomposition:
- Package dot_acc_pkg:
  - state enum {IDLE, ACCUM, DONE}.
  - function sat_add(acc, addend) returning a saturated value plus an overflow bit.
  - Width localparams derived from N and ACC_W.
- No sub-module is needed.
- For integration benches, the bench instantiates the multiplier and the accumulator side by side; the multiplier output drives product.

Test Plan:
- Defaults (N=5, LEN=4, ACC_W=12), out_ready=1, back-to-back products 15, -9, 6, -50 → one cycle after 4th beat: out_valid=1, result=-38 (12'hFDA), ovf=0; out_valid=0 next cycle; in_ready=0 only during DONE cycle.
- ACC_W=10, products 256, 256, 256, 256 (i.e. -16*-16) → result=511, ovf=1. Next group 1, 1, 1, 1 → result=4, ovf=0 (sticky flag cleared per group).
- Backpressure: out_ready=0 for 5 cycles after group 3, 3, 3, 3 → result=12 held stable with out_valid=1, in_ready=0, in_valid=1 with product 7 not consumed. Raise out_ready → handshake, then 7 is accepted as the first beat of the next group.
- clear mid-group: accept 100, 100; assert clear together with in_valid and product 100 → beat dropped, state IDLE. Then 1, 2, 3, 4 → result=10.
- In-valid gaps: products 5, -5, 20, -1 with in_valid low 2 cycles between each → result=19, single out_valid pulse with out_ready=1.
- Async reset mid-group after 2 beats, asserted between clock edges → outputs 0 immediately. After release, group 1, 1, 1, 1 → result=4.
